// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state
// encoding and the start-to-done latency used by stall logic.
package mul_pkg;

    // Controller states. IDLE waits for Start, CALC retires BPC multiplier
    // bits per edge, FIX applies the sign correction and publishes Produto.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } mul_state_e;

    // Edges from the accepting Start edge to the edge that raises Done.
    function automatic int mul_latency(input int width, input int bpc);
        return (width / bpc) + 1;
    endfunction

    // Counter width able to hold the step count WIDTH/BPC.
    function automatic int mul_count_width(input int width, input int bpc);
        return $clog2((width / bpc) + 1);
    endfunction

endpackage

// File: rtl/mul_pp_adder.sv
// One shift-add step: forms the partial product |A| x digit, where digit is
// the next BPC multiplier bits, and adds it to the accumulator upper half.
module mul_pp_adder
    import mul_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BPC   = 2
) (
    input  logic [WIDTH-1:0]     mcand_i,
    input  logic [BPC-1:0]       digit_i,
    input  logic [WIDTH+BPC-1:0] acc_hi_i,
    output logic [WIDTH+BPC-1:0] sum_o
);

    logic [WIDTH+BPC-1:0] mcand_ext;
    logic [WIDTH+BPC-1:0] digit_ext;
    logic [WIDTH+BPC-1:0] pp;

    // Both operands are widened to the partial-product width so the product
    // of a WIDTH-bit magnitude and a BPC-bit digit is never truncated. The
    // incoming upper half is always below 2^WIDTH, so the sum also fits.
    always_comb begin
        mcand_ext = {{BPC{1'b0}}, mcand_i};
        digit_ext = {{WIDTH{1'b0}}, digit_i};
        pp        = mcand_ext * digit_ext;
        sum_o     = acc_hi_i + pp;
    end

endmodule

// File: rtl/multiplicador_seq.sv
// Sequential shift-add multiplier, signed or unsigned, retiring BPC
// multiplier bits per clock.
//
// Handshake: Start is sampled only while idle (Busy low); an accepted Start
// captures both operands and Signed, and raises Busy on that same edge.
// Start seen while Busy is dropped, never queued. Busy falls on the edge
// that raises Done; Done is a one-cycle pulse and Produto holds the result
// until the next completion. Start high during the Done cycle is accepted.
module multiplicador_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BPC   = 2
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Signed,
    input  logic [WIDTH-1:0]     Multiplicando,
    input  logic [WIDTH-1:0]     Multiplicador,
    output logic                 Busy,
    output logic                 Done,
    output logic [2*WIDTH-1:0]   Produto,
    output logic [1:0]           dbg_state_o
);

    localparam int N  = WIDTH / BPC;
    localparam int CW = mul_count_width(WIDTH, BPC);

    // Reject configurations the datapath cannot support.
    if ((BPC != 1 && BPC != 2 && BPC != 4) || WIDTH < 4 || (WIDTH % BPC) != 0) begin : g_param_check
        $error("multiplicador_seq: WIDTH must be >= 4 and divisible by BPC, BPC in {1,2,4}");
    end

    mul_state_e             state_q;
    logic [WIDTH-1:0]       mcand_q;
    logic [WIDTH-1:0]       mplier_q;
    logic [WIDTH+BPC-1:0]   acc_hi_q;
    logic                   neg_q;
    logic [CW-1:0]          count_q;
    logic                   busy_q;
    logic                   done_q;
    logic [2*WIDTH-1:0]     prod_q;

    logic [WIDTH-1:0]       mag_a;
    logic [WIDTH-1:0]       mag_b;
    logic                   neg_d;
    logic [WIDTH+BPC-1:0]   sum_hi;
    logic [WIDTH+BPC-1:0]   acc_hi_d;
    logic [WIDTH-1:0]       mplier_d;
    logic [2*WIDTH-1:0]     acc_full;
    logic [2*WIDTH-1:0]     prod_d;

    // Operand magnitudes for capture. The magnitude of the most negative
    // value, 2^(WIDTH-1), is still representable as a WIDTH-bit unsigned.
    always_comb begin
        mag_a = Multiplicando;
        mag_b = Multiplicador;
        if (Signed && Multiplicando[WIDTH-1]) begin
            mag_a = WIDTH'(0) - Multiplicando;
        end
        if (Signed && Multiplicador[WIDTH-1]) begin
            mag_b = WIDTH'(0) - Multiplicador;
        end
        neg_d = Signed & (Multiplicando[WIDTH-1] ^ Multiplicador[WIDTH-1]);
    end

    mul_pp_adder #(
        .WIDTH (WIDTH),
        .BPC   (BPC)
    ) u_pp_adder (
        .mcand_i  (mcand_q),
        .digit_i  (mplier_q[BPC-1:0]),
        .acc_hi_i (acc_hi_q),
        .sum_o    (sum_hi)
    );

    // Shift the {upper, multiplier} pair right by BPC after the add; the
    // low bits of the sum drop into the vacated top of the multiplier
    // register, which therefore ends up holding the product's lower half.
    always_comb begin
        acc_hi_d = {{BPC{1'b0}}, sum_hi[WIDTH+BPC-1:BPC]};
        mplier_d = {sum_hi[BPC-1:0], mplier_q[WIDTH-1:BPC]};
        acc_full = {acc_hi_q[WIDTH-1:0], mplier_q};
        prod_d   = neg_q ? ((2*WIDTH)'(0) - acc_full) : acc_full;
    end

    // Controller: operand capture, step counting, sign fix and registered
    // Busy/Done/Produto. Reset discards any product in flight.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_hi_q <= '0;
            neg_q    <= 1'b0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            prod_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (Start) begin
                        mcand_q  <= mag_a;
                        mplier_q <= mag_b;
                        neg_q    <= neg_d;
                        acc_hi_q <= '0;
                        count_q  <= CW'(N);
                        busy_q   <= 1'b1;
                        state_q  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc_hi_q <= acc_hi_d;
                    mplier_q <= mplier_d;
                    count_q  <= count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    prod_q  <= prod_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign Busy        = busy_q;
    assign Done        = done_q;
    assign Produto     = prod_q;
    assign dbg_state_o = state_q;

endmodule
